// File: rtl/serial_adder_pkg.sv
// Shared types, pin indices and helpers for the bit-serial adder/subtractor tile.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int UI_A_BIT     = 32'sd0;
   localparam int UI_B_BIT     = 32'sd1;
   localparam int UI_BIT_VALID = 32'sd2;
   localparam int UI_START     = 32'sd3;
   localparam int UI_MODE      = 32'sd4;
   localparam int UI_RD_NEXT   = 32'sd5;

   localparam int UO_SUM       = 32'sd0;
   localparam int UO_CARRY     = 32'sd1;
   localparam int UO_BUSY      = 32'sd2;
   localparam int UO_DONE      = 32'sd3;
   localparam int UO_OVERFLOW  = 32'sd4;

   function automatic bit width_ok(input int w);
      return (w >= 32'sd8) && (w <= 32'sd64) && ((w % 32'sd8) == 32'sd0);
   endfunction

   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One registered full-adder stage: sum and carry registers plus the carry that fed the last bit.
module serial_fa_cell
   import serial_adder_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   input  logic b,
   input  logic load,
   input  logic load_val,
   input  logic en,
   output logic s_q,
   output logic c_q,
   output logic c_in_prev
);

   // Sum/carry state; load seeds the carry (1 gives the +1 of two's-complement subtract).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q       <= 1'b0;
         c_q       <= 1'b0;
         c_in_prev <= 1'b0;
      end else if (load) begin
         s_q       <= 1'b0;
         c_q       <= load_val;
         c_in_prev <= 1'b0;
      end else if (en) begin
         s_q       <= a ^ b ^ c_q;
         c_q       <= maj3(a, b, c_q);
         c_in_prev <= c_q;
      end
   end

endmodule

// File: rtl/tt_um_serial_adder_christ.sv
// Bit-serial adder/subtractor tile: LSB-first operand bits in, byte-wise result readback out.
module tt_um_serial_adder_christ
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena,
   input  logic       clk,
   input  logic       rst_n
);

   localparam int CW = $clog2(WIDTH);
   localparam int NB = WIDTH / 8;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [BW-1:0] SEL_LAST = BW'(NB - 1);

   generate
      if (!width_ok(WIDTH)) begin : g_bad_width
         $error("tt_um_serial_adder_christ: WIDTH must be a multiple of 8 in 8..64");
      end
   endgenerate

   state_e           state_r;
   logic             mode_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] result_r;
   logic [BW-1:0]    byte_sel_r;

   logic a_bit_s, b_bit_s, bit_valid_s, start_s, mode_s, rd_next_s;
   logic b_eff_s, sum_s, bit_en_s;
   logic s_q_s, c_q_s, c_in_prev_s;
   logic busy_s, done_s, overflow_s;
   logic [7:0] rd_byte_s;
   logic unused_s;

   assign a_bit_s     = ui_in[UI_A_BIT];
   assign b_bit_s     = ui_in[UI_B_BIT];
   assign bit_valid_s = ui_in[UI_BIT_VALID];
   assign start_s     = ui_in[UI_START];
   assign mode_s      = ui_in[UI_MODE];
   assign rd_next_s   = ui_in[UI_RD_NEXT];
   assign unused_s    = &{1'b0, ena, uio_in, ui_in[7:6]};

   // start has priority, so a bit strobed in the same cycle never reaches the adder
   assign b_eff_s  = b_bit_s ^ mode_r;
   assign sum_s    = a_bit_s ^ b_eff_s ^ c_q_s;
   assign bit_en_s = (state_r == RUN) && bit_valid_s && !start_s;

   serial_fa_cell u_fa (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a_bit_s),
      .b         (b_eff_s),
      .load      (start_s),
      .load_val  (mode_s),
      .en        (bit_en_s),
      .s_q       (s_q_s),
      .c_q       (c_q_s),
      .c_in_prev (c_in_prev_s)
   );

   // Sequencing FSM, bit counter, result shift register and readback byte pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         mode_r     <= 1'b0;
         cnt_r      <= {CW{1'b0}};
         result_r   <= {WIDTH{1'b0}};
         byte_sel_r <= {BW{1'b0}};
      end else if (start_s) begin
         state_r    <= RUN;
         mode_r     <= mode_s;
         cnt_r      <= {CW{1'b0}};
         result_r   <= {WIDTH{1'b0}};
         byte_sel_r <= {BW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               state_r <= IDLE;
            end
            RUN: begin
               if (bit_valid_s) begin
                  result_r <= {sum_s, result_r[WIDTH-1:1]};
                  cnt_r    <= cnt_r + CW'(1);
                  if (cnt_r == CNT_LAST) begin
                     state_r <= DONE;
                  end
               end
            end
            DONE: begin
               if (rd_next_s) begin
                  byte_sel_r <= (byte_sel_r == SEL_LAST) ? {BW{1'b0}} : byte_sel_r + BW'(1);
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Readback byte selection.
   always_comb begin
      rd_byte_s = 8'h00;
      for (int i = 0; i < NB; i++) begin
         rd_byte_s = (byte_sel_r == BW'(i)) ? result_r[8*i +: 8] : rd_byte_s;
      end
   end

   assign busy_s = (state_r == RUN);
   assign done_s = (state_r == DONE);
   // The cell stops after the MSB, so its carry pair still describes the MSB while in DONE.
   assign overflow_s = done_s & (c_in_prev_s ^ c_q_s);

   assign uo_out[UO_SUM]      = s_q_s;
   assign uo_out[UO_CARRY]    = c_q_s;
   assign uo_out[UO_BUSY]     = busy_s;
   assign uo_out[UO_DONE]     = done_s;
   assign uo_out[UO_OVERFLOW] = overflow_s;
   assign uo_out[7:5]         = 3'b000;
   assign uio_out             = done_s ? rd_byte_s : 8'h00;
   assign uio_oe              = 8'hFF;

endmodule

// File: tb/tb_tt_um_serial_adder_christ.sv
// Self-checking bench: WIDTH 64/16/8 instances share stimulus; results checked against a scoreboard.
module tb_tt_um_serial_adder_christ;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uo64, uio64, oe64, uo16, uio16, oe16, uo8, uio8, oe8;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tt_um_serial_adder_christ #(.WIDTH(64)) dut64 (
      .ui_in(ui_in), .uo_out(uo64), .uio_in(8'h00), .uio_out(uio64), .uio_oe(oe64),
      .ena(1'b1), .clk(clk), .rst_n(rst_n));
   tt_um_serial_adder_christ #(.WIDTH(16)) dut16 (
      .ui_in(ui_in), .uo_out(uo16), .uio_in(8'h00), .uio_out(uio16), .uio_oe(oe16),
      .ena(1'b1), .clk(clk), .rst_n(rst_n));
   tt_um_serial_adder_christ #(.WIDTH(8)) dut8 (
      .ui_in(ui_in), .uo_out(uo8), .uio_in(8'h00), .uio_out(uio8), .uio_oe(oe8),
      .ena(1'b1), .clk(clk), .rst_n(rst_n));

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        m;
      int          gap;
      logic [15:0] r16;
      logic        c16;
      logic        v16;
   } vec_t;

   typedef struct {
      logic [63:0] r64; logic c64; logic v64;
      logic [15:0] r16; logic c16; logic v16;
      logic [7:0]  r8;  logic c8;  logic v8;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[7];

   // Arithmetic reference: returns {carry, overflow, result} for width w.
   function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic m, input int w);
      logic [63:0] mask, a_m, b_e, res;
      logic [64:0] sum;
      logic        c, v;
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      a_m  = a & mask;
      b_e  = (m ? ~b : b) & mask;
      sum  = {1'b0, a_m} + {1'b0, b_e} + {64'd0, m};
      res  = sum[63:0] & mask;
      c    = sum[w];
      v    = (a_m[w-1] == b_e[w-1]) && (res[w-1] != a_m[w-1]);
      return {c, v, res};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pulse(input logic [7:0] v);
      ui_in = v;
      @(negedge clk);
      ui_in = 8'h00;
   endtask

   task automatic push_exp(input logic [63:0] a, input logic [63:0] b, input logic m,
                           input logic [15:0] r16, input logic c16, input logic v16);
      exp_t e;
      logic [65:0] x;
      x = model(a, b, m, 64);
      e.r64 = x[63:0]; e.v64 = x[64]; e.c64 = x[65];
      x = model(a, b, m, 8);
      e.r8 = x[7:0]; e.v8 = x[64]; e.c8 = x[65];
      e.r16 = r16; e.c16 = c16; e.v16 = v16;
      sb_q.push_back(e);
   endtask

   task automatic do_start(input logic m);
      pulse({3'b000, m, 1'b1, 3'b000});
      chk("start_busy16", {63'd0, uo16[2]}, 64'd1);
      chk("start_carry16", {63'd0, uo16[1]}, {63'd0, m});
      chk("start_done16", {63'd0, uo16[3]}, 64'd0);
   endtask

   task automatic feed_bits(input logic [63:0] a, input logic [63:0] b, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, gap)) @(negedge clk);
         pulse({5'b00001, b[i], a[i]} << 0 | 8'h04);
      end
   endtask

   task automatic chk_dut(input string tag, input logic [7:0] uo, input logic c,
                          input logic v, input logic msb);
      chk({tag, "_done"}, {63'd0, uo[3]}, 64'd1);
      chk({tag, "_busy"}, {63'd0, uo[2]}, 64'd0);
      chk({tag, "_carry"}, {63'd0, uo[1]}, {63'd0, c});
      chk({tag, "_ovf"}, {63'd0, uo[4]}, {63'd0, v});
      chk({tag, "_sum"}, {63'd0, uo[0]}, {63'd0, msb});
      chk({tag, "_hi"}, {61'd0, uo[7:5]}, 64'd0);
   endtask

   task automatic check_result();
      exp_t e;
      for (int t = 0; t < 8 && uo64[3] !== 1'b1; t++) @(negedge clk);
      if (sb_q.size() == 0) begin
         chk("sb_empty", 64'd0, 64'd1);
         return;
      end
      e = sb_q.pop_front();
      chk_dut("w64", uo64, e.c64, e.v64, e.r64[63]);
      chk_dut("w16", uo16, e.c16, e.v16, e.r16[15]);
      chk_dut("w8", uo8, e.c8, e.v8, e.r8[7]);
      for (int k = 0; k <= 8; k++) begin
         chk("rd_w64", {56'd0, uio64}, {56'd0, e.r64[8*(k%8) +: 8]});
         chk("rd_w16", {56'd0, uio16}, {56'd0, e.r16[8*(k%2) +: 8]});
         chk("rd_w8", {56'd0, uio8}, {56'd0, e.r8});
         pulse(8'h20);
      end
   endtask

   initial begin
      vecs[0] = '{64'h00FF, 64'h0001, 1'b0, 0, 16'h0100, 1'b0, 1'b0};
      vecs[1] = '{64'h7FFF, 64'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1};
      vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0};
      vecs[3] = '{64'h0005, 64'h0007, 1'b1, 3, 16'hFFFE, 1'b0, 1'b0};
      vecs[4] = '{64'h0007, 64'h0005, 1'b1, 3, 16'h0002, 1'b1, 1'b0};
      vecs[5] = '{64'h0080, 64'h0001, 1'b1, 0, 16'h007F, 1'b1, 1'b0};
      vecs[6] = '{64'h1234, 64'h1111, 1'b0, 2, 16'h2345, 1'b0, 1'b0};

      repeat (3) @(negedge clk);
      chk("rst_uo16", {56'd0, uo16}, 64'd0);
      chk("rst_uo64", {56'd0, uo64}, 64'd0);
      chk("rst_uo8", {56'd0, uo8}, 64'd0);
      chk("rst_uio16", {56'd0, uio16}, 64'd0);
      chk("rst_oe16", {56'd0, oe16}, 64'hFF);
      chk("rst_oe64", {56'd0, oe64}, 64'hFF);
      rst_n = 1'b1;
      @(negedge clk);

      repeat (3) pulse(8'h07);
      pulse(8'h20);
      chk("idle_done16", {63'd0, uo16[3]}, 64'd0);
      chk("idle_uo16", {56'd0, uo16}, 64'd0);
      chk("idle_uo8", {56'd0, uo8}, 64'd0);
      chk("idle_uio16", {56'd0, uio16}, 64'd0);

      foreach (vecs[i]) begin
         push_exp(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].r16, vecs[i].c16, vecs[i].v16);
         do_start(vecs[i].m);
         feed_bits(vecs[i].a, vecs[i].b, 64, vecs[i].gap);
         check_result();
      end

      // start + rd_next in DONE: start wins; then restart after 6 bits with a same-cycle strobe
      pulse(8'h28);
      chk("int_busy16", {63'd0, uo16[2]}, 64'd1);
      chk("int_uio16", {56'd0, uio16}, 64'd0);
      feed_bits(64'h3F, 64'h3F, 6, 0);
      chk("int6_busy16", {63'd0, uo16[2]}, 64'd1);
      chk("int6_done16", {63'd0, uo16[3]}, 64'd0);
      pulse(8'h0F);
      chk("sv_busy16", {63'd0, uo16[2]}, 64'd1);
      chk("sv_carry16", {63'd0, uo16[1]}, 64'd0);
      chk("sv_sum16", {63'd0, uo16[0]}, 64'd0);
      push_exp(64'h1234, 64'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
      feed_bits(64'h1234, 64'h1111, 64, 0);
      check_result();

      do_start(1'b1);
      feed_bits(64'h1234, 64'h1111, 5, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_uo16", {56'd0, uo16}, 64'd0);
      chk("mrst_uo64", {56'd0, uo64}, 64'd0);
      chk("mrst_uo8", {56'd0, uo8}, 64'd0);
      chk("mrst_uio16", {56'd0, uio16}, 64'd0);
      chk("mrst_oe16", {56'd0, oe16}, 64'hFF);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_uo16", {56'd0, uo16}, 64'd0);

      push_exp(vecs[3].a, vecs[3].b, vecs[3].m, vecs[3].r16, vecs[3].c16, vecs[3].v16);
      do_start(vecs[3].m);
      feed_bits(vecs[3].a, vecs[3].b, 64, 2);
      check_result();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
